uart_ram_sequencer: RTL and testbench



---
 rtl/ram_uart_pkg.sv | 36 +++
 rtl/uart_ram_sequencer_if.sv | 30 +++
 rtl/uart_ram_sequencer_phase_timer.sv | 36 +++
 rtl/uart_ram_sequencer.sv | 260 ++++++++++++++++++++++++++
 tb/tb_uart_ram_sequencer.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_uart_pkg.sv
// Shared types and constants for the UART-to-SRAM command sequencer.
// Command bytes, RAM widths, FSM state encoding and counter sizing helpers.
package ram_uart_pkg;

  localparam int RAM_AW = 18;
  localparam int RAM_DW = 16;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_GET_A2,
    ST_GET_A1,
    ST_GET_A0,
    ST_GET_D1,
    ST_GET_D0,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD,
    ST_RD_STROBE,
    ST_TX_HI,
    ST_TX_LO,
    ST_TX_ACK
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold the value v (at least one).
  function automatic int width_for(input int v);
    return (v < 2) ? 1 : $clog2(v + 1);
  endfunction

endpackage

// File: rtl/uart_ram_sequencer_if.sv
// Bundle of UART byte streams and SRAM controller strobes around the sequencer.
// master = sequencer side, slave = the UART/controller side.
interface uart_ram_sequencer_if;
  import ram_uart_pkg::*;

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              en;
  logic              re;
  logic              we;
  logic [RAM_AW-1:0] addr_in;
  logic [RAM_DW-1:0] data_in;
  logic [RAM_DW-1:0] data_out;
  logic              busy;
  logic              overrun;

  modport master (
    input  rx_data, rx_valid, tx_ready, data_out,
    output tx_data, tx_valid, en, re, we, addr_in, data_in, busy, overrun
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, data_out,
    input  tx_data, tx_valid, en, re, we, addr_in, data_in, busy, overrun
  );

endinterface

// File: rtl/uart_ram_sequencer_phase_timer.sv
// Loadable down-counter with a zero flag; load wins over decrement and the
// count saturates at zero.
module phase_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/uart_ram_sequencer.sv
// Assembles 'W'/'R' byte commands from the UART, strobes the SRAM controller
// with counted setup/pulse/hold phases, and returns read data or an ack byte.
module uart_ram_sequencer
  import ram_uart_pkg::*;
#(
  parameter int         SETUP_CYCLES   = 2,
  parameter int         PULSE_CYCLES   = 4,
  parameter int         HOLD_CYCLES    = 2,
  parameter int         READ_CYCLES    = 4,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] ACK_BYTE       = 8'h4B
) (
  input logic                  clk,
  input logic                  rst,
  uart_ram_sequencer_if.master bus
);

  // The read phase gets one extra address-settle cycle, hence READ_CYCLES (not -1).
  localparam int PH_MAX = max_int(max_int(SETUP_CYCLES - 1, PULSE_CYCLES - 1),
                                  max_int(HOLD_CYCLES - 1, READ_CYCLES));
  localparam int PH_W   = width_for(PH_MAX);
  localparam int TO_W   = width_for(TIMEOUT_CYCLES - 1);

  localparam logic [PH_W-1:0] PH_SETUP = PH_W'(SETUP_CYCLES - 1);
  localparam logic [PH_W-1:0] PH_PULSE = PH_W'(PULSE_CYCLES - 1);
  localparam logic [PH_W-1:0] PH_HOLD  = PH_W'(HOLD_CYCLES - 1);
  localparam logic [PH_W-1:0] PH_READ  = PH_W'(READ_CYCLES);
  localparam logic [TO_W-1:0] TO_LOAD  = TO_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic              cmd_wr_q, cmd_wr_d;
  logic [1:0]        a2_q, a2_d;
  logic [7:0]        a1_q, a1_d;
  logic [7:0]        a0_q, a0_d;
  logic [7:0]        d1_q, d1_d;
  logic [RAM_DW-1:0] rd_data_q, rd_data_d;
  logic [RAM_AW-1:0] addr_q, addr_d;
  logic [RAM_DW-1:0] data_q, data_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              en_q, en_d;
  logic              re_q, re_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;

  logic              ph_load, ph_dec, ph_zero;
  logic [PH_W-1:0]   ph_val;
  logic              to_load, to_dec, to_zero;
  logic              in_get, in_wr, in_busy_io;

  phase_timer #(.WIDTH(PH_W)) u_phase (
    .clk        (clk),
    .rst        (rst),
    .load_i     (ph_load),
    .load_val_i (ph_val),
    .dec_i      (ph_dec),
    .zero_o     (ph_zero)
  );

  phase_timer #(.WIDTH(TO_W)) u_timeout (
    .clk        (clk),
    .rst        (rst),
    .load_i     (to_load),
    .load_val_i (TO_LOAD),
    .dec_i      (to_dec),
    .zero_o     (to_zero)
  );

  assign in_get     = state_q inside {ST_GET_A2, ST_GET_A1, ST_GET_A0, ST_GET_D1, ST_GET_D0};
  assign in_wr      = state_q inside {ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD};
  assign in_busy_io = in_wr || (state_q inside {ST_RD_STROBE, ST_TX_HI, ST_TX_LO, ST_TX_ACK});

  always_comb begin
    state_d    = state_q;
    cmd_wr_d   = cmd_wr_q;
    a2_d       = a2_q;
    a1_d       = a1_q;
    a0_d       = a0_q;
    d1_d       = d1_q;
    rd_data_d  = rd_data_q;
    addr_d     = addr_q;
    data_d     = data_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    ph_load    = 1'b0;
    ph_val     = PH_SETUP;
    ph_dec     = 1'b1;
    to_load    = !in_get;
    to_dec     = in_get;
    overrun_d  = bus.rx_valid && in_busy_io;

    // Strobes follow the registered state one cycle late, so they never move on
    // the same edge that loads addr_in/data_in.
    en_d = !(in_wr || ((state_q == ST_RD_STROBE) && !ph_zero));
    re_d = (state_q == ST_RD_STROBE) && !ph_zero;
    we_d = (state_q == ST_WR_PULSE);

    case (state_q)
      ST_IDLE: begin
        if (bus.rx_valid && ((bus.rx_data == CMD_WRITE) || (bus.rx_data == CMD_READ))) begin
          cmd_wr_d = (bus.rx_data == CMD_WRITE);
          state_d  = ST_GET_A2;
        end
      end
      ST_GET_A2: begin
        if (bus.rx_valid) begin
          a2_d    = bus.rx_data[1:0];
          to_load = 1'b1;
          state_d = ST_GET_A1;
        end else if (to_zero) begin
          state_d = ST_IDLE;
        end
      end
      ST_GET_A1: begin
        if (bus.rx_valid) begin
          a1_d    = bus.rx_data;
          to_load = 1'b1;
          state_d = ST_GET_A0;
        end else if (to_zero) begin
          state_d = ST_IDLE;
        end
      end
      ST_GET_A0: begin
        if (bus.rx_valid) begin
          to_load = 1'b1;
          if (cmd_wr_q) begin
            a0_d    = bus.rx_data;
            state_d = ST_GET_D1;
          end else begin
            addr_d  = {a2_q, a1_q, bus.rx_data};
            ph_load = 1'b1;
            ph_val  = PH_READ;
            state_d = ST_RD_STROBE;
          end
        end else if (to_zero) begin
          state_d = ST_IDLE;
        end
      end
      ST_GET_D1: begin
        if (bus.rx_valid) begin
          d1_d    = bus.rx_data;
          to_load = 1'b1;
          state_d = ST_GET_D0;
        end else if (to_zero) begin
          state_d = ST_IDLE;
        end
      end
      ST_GET_D0: begin
        if (bus.rx_valid) begin
          addr_d  = {a2_q, a1_q, a0_q};
          data_d  = {d1_q, bus.rx_data};
          to_load = 1'b1;
          ph_load = 1'b1;
          ph_val  = PH_SETUP;
          state_d = ST_WR_SETUP;
        end else if (to_zero) begin
          state_d = ST_IDLE;
        end
      end
      ST_WR_SETUP: begin
        if (ph_zero) begin
          ph_load = 1'b1;
          ph_val  = PH_PULSE;
          state_d = ST_WR_PULSE;
        end
      end
      ST_WR_PULSE: begin
        if (ph_zero) begin
          ph_load = 1'b1;
          ph_val  = PH_HOLD;
          state_d = ST_WR_HOLD;
        end
      end
      ST_WR_HOLD: begin
        if (ph_zero) begin
          tx_data_d  = ACK_BYTE;
          tx_valid_d = 1'b1;
          state_d    = ST_TX_ACK;
        end
      end
      ST_RD_STROBE: begin
        // Last cycle with re high: capture read data and present the high byte.
        if (ph_zero) begin
          rd_data_d  = bus.data_out;
          tx_data_d  = bus.data_out[15:8];
          tx_valid_d = 1'b1;
          state_d    = ST_TX_HI;
        end
      end
      ST_TX_HI: begin
        if (bus.tx_ready) begin
          tx_data_d  = rd_data_q[7:0];
          tx_valid_d = 1'b1;
          state_d    = ST_TX_LO;
        end
      end
      ST_TX_LO, ST_TX_ACK: begin
        if (bus.tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cmd_wr_q   <= 1'b0;
      a2_q       <= '0;
      a1_q       <= '0;
      a0_q       <= '0;
      d1_q       <= '0;
      rd_data_q  <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      en_q       <= 1'b1;
      re_q       <= 1'b0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_wr_q   <= cmd_wr_d;
      a2_q       <= a2_d;
      a1_q       <= a1_d;
      a0_q       <= a0_d;
      d1_q       <= d1_d;
      rd_data_q  <= rd_data_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      en_q       <= en_d;
      re_q       <= re_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.en       = en_q;
  assign bus.re       = re_q;
  assign bus.we       = we_q;
  assign bus.addr_in  = addr_q;
  assign bus.data_in  = data_q;
  assign bus.busy     = busy_q;
  assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_uart_ram_sequencer.sv
// Scoreboard bench for uart_ram_sequencer: directed commands push expected RAM
// accesses and tx bytes; independent monitors pop and compare.
module tb_uart_ram_sequencer;
  import ram_uart_pkg::*;

  typedef struct {
    logic              wr;
    logic [RAM_AW-1:0] addr;
    logic [RAM_DW-1:0] data;
  } ram_op_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [RAM_DW-1:0] rd_val = '0;

  int checks = 0;
  int passes = 0;
  int ov_cnt = 0;
  logic inv_bad = 1'b0;

  ram_op_t    scb_ram[$];
  logic [7:0] scb_tx[$];

  uart_ram_sequencer_if bus ();

  uart_ram_sequencer #(.TIMEOUT_CYCLES(100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Controller read model: valid data only while re is high.
  assign bus.data_out = bus.re ? rd_val : 16'hDEAD;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] a2, a1, a0, d1, d0,
                          input logic [RAM_AW-1:0] exp_addr, input logic [RAM_DW-1:0] exp_data);
    ram_op_t op;
    op.wr = 1'b1; op.addr = exp_addr; op.data = exp_data;
    scb_ram.push_back(op);
    scb_tx.push_back(8'h4B);
    send_byte(8'h57); send_byte(a2); send_byte(a1); send_byte(a0); send_byte(d1); send_byte(d0);
  endtask

  task automatic do_read(input logic [7:0] a2, a1, a0, input logic [RAM_AW-1:0] exp_addr,
                         input logic [7:0] exp_hi, exp_lo);
    ram_op_t op;
    op.wr = 1'b0; op.addr = exp_addr; op.data = '0;
    scb_ram.push_back(op);
    scb_tx.push_back(exp_hi);
    scb_tx.push_back(exp_lo);
    send_byte(8'h52); send_byte(a2); send_byte(a1); send_byte(a0);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (bus.busy || scb_tx.size() != 0 || scb_ram.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > budget) begin
        checks++;
        $display("FAIL wait_done: still busy after %0d cycles, tx pending %0d, ram pending %0d",
                 budget, scb_tx.size(), scb_ram.size());
        scb_tx.delete();
        scb_ram.delete();
        return;
      end
    end
  endtask

  task automatic wait_we(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.we && n <= budget);
    if (!bus.we) begin
      checks++;
      $display("FAIL wait_we: we not seen within %0d cycles, got 0 required 1", budget);
    end
  endtask

  // tx monitor
  initial begin
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      if (!rst && bus.tx_valid && bus.tx_ready) begin
        if (scb_tx.size() == 0) begin
          checks++;
          $display("FAIL tx_unexpected: got byte %02h required none", bus.tx_data);
        end else begin
          exp_b = scb_tx.pop_front();
          $display("tx byte %02h (expected %02h)", bus.tx_data, exp_b);
          check("tx_byte", {24'd0, bus.tx_data}, {24'd0, exp_b});
        end
      end
    end
  end

  // RAM access monitor: measures one en-low window per access
  int mon_en_len, mon_we_len, mon_re_len, mon_we_off;
  logic mon_en_prev, mon_stable;
  logic [RAM_AW-1:0] mon_addr;
  logic [RAM_DW-1:0] mon_data;
  initial begin
    ram_op_t op;
    mon_en_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_en_prev = 1'b1;
        mon_en_len = 0;
      end else begin
        if ((bus.re || bus.we) && (bus.en || (bus.re && bus.we))) inv_bad = 1'b1;
        if (!bus.en) begin
          if (mon_en_prev) begin
            mon_addr = bus.addr_in; mon_data = bus.data_in;
            mon_en_len = 0; mon_we_len = 0; mon_re_len = 0; mon_we_off = -1;
            mon_stable = 1'b1;
          end
          mon_en_len++;
          if (bus.we) begin
            if (mon_we_len == 0) mon_we_off = mon_en_len - 1;
            mon_we_len++;
          end
          if (bus.re) mon_re_len++;
          if (bus.addr_in != mon_addr || bus.data_in != mon_data) mon_stable = 1'b0;
        end else if (!mon_en_prev) begin
          if (scb_ram.size() == 0) begin
            checks++;
            $display("FAIL ram_unexpected: got access at addr %05h required none", mon_addr);
          end else begin
            op = scb_ram.pop_front();
            $display("ram %s addr %05h data %04h en_low %0d we %0d re %0d",
                     op.wr ? "write" : "read", mon_addr, mon_data, mon_en_len, mon_we_len, mon_re_len);
            check("ram_addr", {14'd0, mon_addr}, {14'd0, op.addr});
            check("ram_stable", {31'd0, mon_stable}, 32'd1);
            if (op.wr) begin
              check("wr_data", {16'd0, mon_data}, {16'd0, op.data});
              check("wr_en_low", mon_en_len, 8);
              check("wr_we_len", mon_we_len, 4);
              check("wr_we_offset", mon_we_off, 2);
              check("wr_re_len", mon_re_len, 0);
            end else begin
              check("rd_en_low", mon_en_len, 4);
              check("rd_re_len", mon_re_len, 4);
              check("rd_we_len", mon_we_len, 0);
            end
          end
        end
        mon_en_prev = bus.en;
      end
    end
  end

  // overrun pulse counter
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.overrun) ov_cnt++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ov_base;
    logic hold_ok;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_en", {31'd0, bus.en}, 32'd1);
    check("rst_re", {31'd0, bus.re}, 32'd0);
    check("rst_we", {31'd0, bus.we}, 32'd0);
    check("rst_addr", {14'd0, bus.addr_in}, 32'd0);
    check("rst_data", {16'd0, bus.data_in}, 32'd0);
    check("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
    check("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_overrun", {31'd0, bus.overrun}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // non-command byte in IDLE is ignored without overrun
    send_byte(8'h41);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("idle_junk_busy", {31'd0, bus.busy}, 32'd0);
    check("idle_junk_overrun", ov_cnt, 0);

    // write
    do_write(8'h00, 8'h12, 8'h34, 8'hAB, 8'hCD, 18'h01234, 16'hABCD);
    wait_done(200);

    // read with tx back-pressure on the first byte
    rd_val = 16'h5AA5;
    bus.tx_ready = 1'b0;
    do_read(8'h03, 8'hFF, 8'hFF, 18'h3FFFF, 8'h5A, 8'hA5);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.tx_valid && n <= 50);
    check("rd_tx_valid_seen", {31'd0, bus.tx_valid}, 32'd1);
    hold_ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!bus.tx_valid || bus.tx_data != 8'h5A) hold_ok = 1'b0;
    end
    check("rd_tx_hold_stable", {31'd0, hold_ok}, 32'd1);
    @(posedge clk); #1;
    bus.tx_ready = 1'b1;
    wait_done(200);

    // address truncation: A2[7:2] ignored
    rd_val = 16'h1234;
    do_read(8'hFE, 8'h00, 8'h01, 18'h20001, 8'h12, 8'h34);
    wait_done(200);

    // timeout: two bytes then silence, nothing reaches RAM or tx
    send_byte(8'h57);
    send_byte(8'h00);
    repeat (95) @(posedge clk);
    @(negedge clk);
    check("timeout_still_busy", {31'd0, bus.busy}, 32'd1);
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("timeout_idle", {31'd0, bus.busy}, 32'd0);
    rd_val = 16'hC33C;
    do_read(8'h00, 8'h00, 8'h00, 18'h00000, 8'hC3, 8'h3C);
    wait_done(200);

    // overrun: three bytes injected while the write strobe is active
    ov_base = ov_cnt;
    do_write(8'h01, 8'h00, 8'h10, 8'h55, 8'hAA, 18'h10010, 16'h55AA);
    wait_we(50);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus.rx_data  = 8'h57;
      bus.rx_valid = 1'b1;
    end
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    wait_done(200);
    check("overrun_pulses", ov_cnt - ov_base, 3);

    // reset during the write pulse
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h05); send_byte(8'h11); send_byte(8'h22);
    wait_we(50);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_en", {31'd0, bus.en}, 32'd1);
    check("midrst_we", {31'd0, bus.we}, 32'd0);
    check("midrst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // recovery after reset
    rd_val = 16'h0FF0;
    do_read(8'h02, 8'h40, 8'h80, 18'h24080, 8'h0F, 8'hF0);
    wait_done(200);

    check("strobe_invariant", {31'd0, inv_bad}, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
